udp_tx_feeder: RTL and testbench

//  Packet buffer between the user data source and the UDP transmit interface.

---
 rtl/udp_pkg.sv | 24 ++
 rtl/udp_sdpram.sv | 32 +++
 rtl/udp_tx_feeder.sv | 164 ++++++++++++++++
 tb/tb_udp_tx_feeder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP transmit packet feeder.
// Word format is big-endian: byte 0 of the packet sits in bits [31:24].
package udp_pkg;

  localparam int BYTE_CNT_W     = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTES_PER_WORD * 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    SEND  = 2'd3
  } state_e;

  // Length of a packet whose last word sits at index full_words; 0 in last_bytes means a full word.
  function automatic logic [BYTE_CNT_W-1:0] pkt_len(input logic [BYTE_CNT_W-1:0] full_words,
                                                    input logic [1:0]            last_bytes);
    logic [BYTE_CNT_W-1:0] tail;
    tail = (last_bytes == 2'd0) ? BYTE_CNT_W'(BYTES_PER_WORD) : BYTE_CNT_W'(last_bytes);
    return (full_words * BYTE_CNT_W'(BYTES_PER_WORD)) + tail;
  endfunction

endpackage

// File: rtl/udp_sdpram.sv
// Simple dual-port word RAM: one write port, one registered read port, 1-cycle read latency.
// Read data holds its last value while rd_en is low; no reset on the storage or read register.
module udp_sdpram
  import udp_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/udp_tx_feeder.sv
// Single-packet buffer: user fills words, block announces length, serves one word per tx_req (1-cycle latency).
// Writes are refused (wr_ready=0) from the accepted last word until tx_done or timeout; overflow drops the packet.
module udp_tx_feeder
  import udp_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DONE_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  wr_last,
  input  logic [1:0]            wr_bytes,
  output logic                  wr_ready,
  output logic                  tx_start_en,
  output logic [BYTE_CNT_W-1:0] tx_byte_num,
  input  logic                  tx_req,
  output logic [WORD_W-1:0]     tx_data,
  input  logic                  tx_done,
  output logic                  drop,
  output logic                  tx_err
);

  localparam int                TMO_W    = $clog2(DONE_TIMEOUT + 1);
  localparam int                PTR_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        word_cnt_q, word_cnt_d;
  logic [BYTE_CNT_W-1:0]   byte_num_q, byte_num_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    discard_q, discard_d;
  logic                    wr_ready_q, wr_ready_d;
  logic                    rd_vld_q, rd_vld_d;

  logic                    wr_acc;
  logic                    mem_we;
  logic                    mem_re;
  logic [ADDR_W-1:0]       mem_raddr;
  logic [WORD_W-1:0]       mem_rdata;

  assign wr_acc = wr_en && wr_ready_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    word_cnt_d  = word_cnt_q;
    byte_num_d  = byte_num_q;
    tmo_d       = tmo_q;
    discard_d   = discard_q;
    rd_vld_d    = rd_vld_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_raddr   = rd_ptr_q[ADDR_W-1:0];
    tx_start_en = 1'b0;
    drop        = 1'b0;
    tx_err      = 1'b0;

    case (state_q)
      FILL: begin
        if (wr_acc) begin
          if (discard_q) begin
            // Swallow the rest of an overflowed packet, including its last word.
            if (wr_last) begin
              discard_d = 1'b0;
            end
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_last) begin
              byte_num_d = pkt_len(BYTE_CNT_W'(wr_ptr_q), wr_bytes);
              word_cnt_d = {1'b0, wr_ptr_q} + 1'b1;
              state_d    = LOAD;
            end else if (wr_ptr_q == PTR_LAST) begin
              drop      = 1'b1;
              wr_ptr_d  = '0;
              discard_d = 1'b1;
            end
          end
        end
      end
      LOAD: begin
        mem_re    = 1'b1;
        mem_raddr = '0;
        rd_vld_d  = 1'b1;
        rd_ptr_d  = PTR_W'(1);
        state_d   = START;
      end
      START: begin
        tx_start_en = 1'b1;
        tmo_d       = TMO_W'(1);
        state_d     = SEND;
      end
      SEND: begin
        tmo_d = tmo_q + 1'b1;
        if (tx_done || (tmo_q == TMO_W'(DONE_TIMEOUT))) begin
          tx_err   = !tx_done;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          rd_vld_d = 1'b0;
          state_d  = FILL;
        end else if (tx_req) begin
          if (rd_ptr_q < word_cnt_q) begin
            mem_re   = 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
            rd_vld_d = 1'b1;
          end else begin
            rd_vld_d = 1'b0;
          end
        end
      end
      default: state_d = FILL;
    endcase

    wr_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      word_cnt_q <= '0;
      byte_num_q <= '0;
      tmo_q      <= '0;
      discard_q  <= 1'b0;
      wr_ready_q <= 1'b0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      word_cnt_q <= word_cnt_d;
      byte_num_q <= byte_num_d;
      tmo_q      <= tmo_d;
      discard_q  <= discard_d;
      wr_ready_q <= wr_ready_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  udp_sdpram #(
    .ADDR_W(ADDR_W),
    .DATA_W(WORD_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_en   (mem_re),
    .rd_addr (mem_raddr),
    .rd_data (mem_rdata)
  );

  // The RAM read register is not reset, so a valid flag masks it to zero.
  assign tx_data     = rd_vld_q ? mem_rdata : '0;
  assign wr_ready    = wr_ready_q;
  assign tx_byte_num = byte_num_q;

endmodule

// File: tb/tb_udp_tx_feeder.sv
// Bench for udp_tx_feeder: packet-level reference model checked every cycle plus directed literal checks.
module tb_udp_tx_feeder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int TMO    = 100;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_last;
  logic [1:0]  wr_bytes;
  logic        wr_ready;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req;
  logic [31:0] tx_data;
  logic        tx_done;
  logic        drop;
  logic        tx_err;

  int n_checks  = 0;
  int n_fail    = 0;
  int drop_cnt  = 0;
  int drop_at   = -1;
  int err_cnt   = 0;
  int start_cnt = 0;
  int wr_idx    = 0;

  // Reference model: words of the packet being built/sent, and cycles elapsed since wr_last was taken.
  logic [31:0] m_words[$];
  int          m_age     = -1;
  int          m_next    = 0;
  logic [31:0] m_data    = '0;
  logic [15:0] m_len     = '0;
  logic        m_ready   = 1'b0;
  logic        m_discard = 1'b0;

  udp_tx_feeder #(
    .ADDR_W(ADDR_W),
    .DONE_TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .wr_bytes    (wr_bytes),
    .wr_ready    (wr_ready),
    .tx_start_en (tx_start_en),
    .tx_byte_num (tx_byte_num),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .drop        (drop),
    .tx_err      (tx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model update at each clock edge (age 0 = read setup cycle, 1 = announce cycle, >=2 = serving).
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_words.delete();
      m_age = -1; m_next = 0; m_data = '0; m_len = '0; m_ready = 1'b0; m_discard = 1'b0;
    end else begin
      if (m_age < 0) begin
        if (wr_en && m_ready) begin
          if (m_discard) begin
            if (wr_last) m_discard = 1'b0;
          end else if (wr_last) begin
            m_words.push_back(wr_data);
            m_len = 16'((m_words.size() - 1) * 4 + ((wr_bytes == 2'd0) ? 4 : int'(wr_bytes)));
            m_age = 0;
          end else if (m_words.size() == DEPTH - 1) begin
            m_words.delete();
            m_discard = 1'b1;
          end else begin
            m_words.push_back(wr_data);
          end
        end
      end else if (m_age == 0) begin
        m_data = m_words[0];
        m_next = 1;
        m_age  = 1;
      end else if (m_age >= 2 && (tx_done || m_age == TMO + 1)) begin
        m_age  = -1;
        m_data = '0;
        m_words.delete();
      end else begin
        if (m_age >= 2 && tx_req) begin
          if (m_next < m_words.size()) begin
            m_data = m_words[m_next];
            m_next++;
          end else begin
            m_data = '0;
          end
        end
        m_age++;
      end
      m_ready = (m_age < 0);
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("wr_ready", 32'(wr_ready), 32'(m_ready));
      chk("tx_start_en", 32'(tx_start_en), 32'(m_age == 1));
      chk("tx_data", tx_data, m_data);
      chk("drop", 32'(drop), 32'(m_age < 0 && m_ready && wr_en && !m_discard && !wr_last
                                  && m_words.size() == DEPTH - 1));
      chk("tx_err", 32'(tx_err), 32'(m_age == TMO + 1 && !tx_done));
      if (m_age >= 1) chk("tx_byte_num", 32'(tx_byte_num), 32'(m_len));
      if (drop) begin drop_cnt++; drop_at = wr_idx; end
      if (tx_err) err_cnt++;
      if (tx_start_en) start_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] d, input logic last, input logic [1:0] b);
    wr_en = 1'b1; wr_data = d; wr_last = last; wr_bytes = b;
    step();
    wr_en = 1'b0; wr_last = 1'b0;
  endtask

  task automatic req_once();
    tx_req = 1'b1;
    step();
    tx_req = 1'b0;
  endtask

  task automatic finish_pkt();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int err_at;
    rst_n = 1'b1; wr_en = 1'b0; wr_data = '0; wr_last = 1'b0; wr_bytes = 2'd0;
    tx_req = 1'b0; tx_done = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_start", 32'(tx_start_en), 32'd0);
    chk("rst_len", 32'(tx_byte_num), 32'd0);
    chk("rst_data", tx_data, 32'd0);
    chk("rst_drop_err", 32'({drop, tx_err}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_wr_ready_low", 32'(wr_ready), 32'd0);
    step();
    @(negedge clk);
    chk("rel_wr_ready_high", 32'(wr_ready), 32'd1);

    // 1: three-word packet, two bytes in the last word, single requests.
    write_word(32'h0102_0304, 1'b0, 2'd0);
    write_word(32'h0506_0708, 1'b0, 2'd0);
    write_word(32'h090A_0B0C, 1'b1, 2'd2);
    step();
    @(negedge clk);
    chk("t1_start", 32'(tx_start_en), 32'd1);
    chk("t1_len", 32'(tx_byte_num), 32'd10);
    chk("t1_w0", tx_data, 32'h0102_0304);
    step();
    req_once(); @(negedge clk); chk("t1_w1", tx_data, 32'h0506_0708);
    req_once(); @(negedge clk); chk("t1_w2", tx_data, 32'h090A_0B0C);
    req_once(); @(negedge clk); chk("t1_past_end", tx_data, 32'd0);
    finish_pkt();
    @(negedge clk);
    chk("t1_ready_after_done", 32'(wr_ready), 32'd1);
    chk("t1_start_pulses", 32'(start_cnt), 32'd1);

    // 2: four full words, continuous requests.
    for (int i = 0; i < 4; i++) write_word(32'hA0A0_0000 + 32'(i), i == 3, 2'd0);
    step();
    @(negedge clk);
    chk("t2_len", 32'(tx_byte_num), 32'd16);
    chk("t2_w0", tx_data, 32'hA0A0_0000);
    step();
    tx_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      @(negedge clk);
      chk("t2_stream", tx_data, (i < 4) ? 32'hA0A0_0000 + 32'(i) : 32'd0);
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0; tx_req = 1'b0;
    @(negedge clk);
    chk("t2_ready_next", 32'(wr_ready), 32'd1);
    chk("t2_data_cleared", tx_data, 32'd0);

    // 6: wr_en held high while busy; tx_done beats a simultaneous tx_req.
    base = drop_cnt;
    write_word(32'hE000_0000, 1'b0, 2'd0);
    write_word(32'hE000_0001, 1'b0, 2'd0);
    write_word(32'hE000_0002, 1'b1, 2'd3);
    wr_en = 1'b1; wr_data = 32'hBAD0_BAD0; wr_last = 1'b0;
    step();
    @(negedge clk);
    chk("t6_len", 32'(tx_byte_num), 32'd11);
    step();
    req_once(); @(negedge clk); chk("t6_w1", tx_data, 32'hE000_0001);
    tx_req = 1'b1; tx_done = 1'b1;
    step();
    tx_req = 1'b0; tx_done = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    chk("t6_done_wins", tx_data, 32'd0);
    chk("t6_no_drop", 32'(drop_cnt - base), 32'd0);
    write_word(32'hF0F0_F0F0, 1'b1, 2'd1);
    step();
    @(negedge clk);
    chk("t6_min_len", 32'(tx_byte_num), 32'd1);
    chk("t6_no_stray_write", tx_data, 32'hF0F0_F0F0);
    step();
    finish_pkt();

    // 3: overflow drops the packet; next packet is clean.
    base = drop_cnt;
    for (int i = 0; i < DEPTH + 1; i++) begin
      wr_idx = i;
      write_word(32'h5500_0000 + 32'(i), 1'b0, 2'd0);
    end
    wr_idx = DEPTH + 1;
    write_word(32'h55FF_FFFF, 1'b1, 2'd2);
    @(negedge clk);
    chk("t3_drop_count", 32'(drop_cnt - base), 32'd1);
    chk("t3_drop_word", 32'(drop_at), 32'(DEPTH - 1));
    chk("t3_still_fill", 32'(wr_ready), 32'd1);
    write_word(32'hC0FF_EE00, 1'b1, 2'd0);
    step();
    @(negedge clk);
    chk("t3_len", 32'(tx_byte_num), 32'd4);
    chk("t3_w0", tx_data, 32'hC0FF_EE00);
    step();
    finish_pkt();

    // 4: no tx_done -> abort after the timeout.
    base = err_cnt;
    err_at = -1;
    write_word(32'h1122_3344, 1'b1, 2'd1);
    step();
    for (int k = 1; k <= TMO + 5; k++) begin
      step();
      @(negedge clk);
      if (tx_err && err_at < 0) err_at = k;
    end
    chk("t4_err_cycle", 32'(err_at), 32'(TMO));
    chk("t4_err_count", 32'(err_cnt - base), 32'd1);
    chk("t4_back_to_fill", 32'(wr_ready), 32'd1);

    // 5: asynchronous reset in the middle of sending.
    write_word(32'h7777_0000, 1'b0, 2'd0);
    write_word(32'h7777_0001, 1'b1, 2'd0);
    step();
    step();
    req_once();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_data", tx_data, 32'd0);
    chk("t5_rst_len", 32'(tx_byte_num), 32'd0);
    chk("t5_rst_flags", 32'({wr_ready, tx_start_en, drop, tx_err}), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    base = start_cnt + err_cnt;
    step();
    @(negedge clk);
    chk("t5_no_pulse_on_exit", 32'(start_cnt + err_cnt - base), 32'd0);
    write_word(32'hD000_000D, 1'b0, 2'd0);
    write_word(32'hD000_001D, 1'b1, 2'd2);
    step();
    @(negedge clk);
    chk("t5_len", 32'(tx_byte_num), 32'd6);
    chk("t5_w0", tx_data, 32'hD000_000D);
    step();
    req_once(); @(negedge clk); chk("t5_w1", tx_data, 32'hD000_001D);
    req_once(); @(negedge clk); chk("t5_past_end", tx_data, 32'd0);
    finish_pkt();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
